// File: rtl/fc_pkg.sv
// Shared types and constants for the pipeline flow controller.
// FSM encoding, register-file widths and the x0 address.
package fc_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef enum logic {
    FC_IDLE = 1'b0,
    FC_BUSY = 1'b1
  } fc_state_e;

endpackage

// File: rtl/fc_hazard_detect.sv
// Load-use comparator between the ID sources and the EX load destination.
// Purely combinational; x0 never produces a hazard.
module fc_hazard_detect
  import fc_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic                  rs1_re,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs2_re,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  load_flag,
  output logic                  hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_re && (rs1_addr == rd_addr);
  assign rs2_hit = rs2_re && (rs2_addr == rd_addr);

  assign hazard = load_flag
               && (rd_addr != REG_X0)
               && (rs1_hit || rs2_hit);

endmodule

// File: rtl/flow_ctrl.sv
// Stall/flush generation with a mul/div hold FSM and watchdog.
// Define FC_PERF_CNT_EN to build the stall/flush event counters.
module flow_ctrl
  import fc_pkg::*;
#(
  parameter int MULDIV_TIMEOUT = 64,
  parameter int CNT_W          = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic                  id_rs1_re_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs2_re_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_load_flag_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  ex_jump_flag_i,
  input  logic [XLEN-1:0]       ex_target_addr_i,
  input  logic                  ex_muldiv_start_i,
  input  logic                  muldiv_done_i,
  output logic                  fc_stall_flag_o,
  output logic                  fc_flush_btype_flag_o,
  output logic                  fc_flush_jtype_flag_o,
  output logic                  fc_jump_en_o,
  output logic [XLEN-1:0]       fc_jump_addr_o,
  output logic                  fc_muldiv_timeout_o,
  output logic [XLEN-1:0]       fc_stall_cnt_o,
  output logic [XLEN-1:0]       fc_flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MULDIV_TIMEOUT - 1);

  fc_state_e        state;
  fc_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             to_q;
  logic             to_set;
  logic             hazard;
  logic             idle;
  logic             flush_b;
  logic             flush_j;
  logic             redirect;
  logic             stall;

  fc_hazard_detect u_hazard (
    .rs1_addr  (id_rs1_addr_i),
    .rs1_re    (id_rs1_re_i),
    .rs2_addr  (id_rs2_addr_i),
    .rs2_re    (id_rs2_re_i),
    .rd_addr   (ex_rd_addr_i),
    .load_flag (ex_load_flag_i),
    .hazard    (hazard)
  );

  // EX is frozen while BUSY, so its redirect is not real yet
  assign idle     = (state == FC_IDLE);
  assign flush_b  = idle && ex_branch_taken_i;
  assign flush_j  = idle && ex_jump_flag_i;
  assign redirect = flush_b || flush_j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FC_IDLE;
      cnt   <= '0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (to_set) to_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    to_set    = 1'b0;
    stall     = 1'b0;
    unique case (state)
      FC_IDLE: begin
        if (ex_muldiv_start_i && !redirect) begin
          state_nxt = FC_BUSY;
          cnt_nxt   = '0;
          stall     = 1'b1;
        end else begin
          stall = hazard && !redirect;
        end
      end
      FC_BUSY: begin
        if (muldiv_done_i) begin
          state_nxt = FC_IDLE;
          cnt_nxt   = '0;
        end else begin
          stall = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = FC_IDLE;
            cnt_nxt   = '0;
            to_set    = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = FC_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held
  assign fc_stall_flag_o       = rst_n && stall;
  assign fc_flush_btype_flag_o = rst_n && flush_b;
  assign fc_flush_jtype_flag_o = rst_n && flush_j;
  assign fc_jump_en_o          = rst_n && redirect;
  assign fc_jump_addr_o        = (rst_n && redirect)
                               ? ex_target_addr_i
                               : '0;
  assign fc_muldiv_timeout_o   = to_q;

`ifdef FC_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt;
  logic [XLEN-1:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)    stall_cnt <= stall_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign fc_stall_cnt_o = stall_cnt;
  assign fc_flush_cnt_o = flush_cnt;
`else
  assign fc_stall_cnt_o = '0;
  assign fc_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_flow_ctrl.sv
// Self-checking bench for flow_ctrl: directed scenarios then random traffic.
// Expected values come from a cycle-level behavioural model of the rules.
module tb_flow_ctrl;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        re1 = 1'b0, re2 = 1'b0, load = 1'b0;
  logic        taken = 1'b0, jump = 1'b0;
  logic [31:0] target = '0;
  logic        start = 1'b0, done = 1'b0;

  logic        stall_o, flush_b_o, flush_j_o, jen_o, to_o;
  logic [31:0] jaddr_o, scnt_o, fcnt_o;

  always #5 clk = ~clk;

  flow_ctrl #(.MULDIV_TIMEOUT(T), .CNT_W(7)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .id_rs1_addr_i         (rs1),
    .id_rs1_re_i           (re1),
    .id_rs2_addr_i         (rs2),
    .id_rs2_re_i           (re2),
    .ex_rd_addr_i          (rd),
    .ex_load_flag_i        (load),
    .ex_branch_taken_i     (taken),
    .ex_jump_flag_i        (jump),
    .ex_target_addr_i      (target),
    .ex_muldiv_start_i     (start),
    .muldiv_done_i         (done),
    .fc_stall_flag_o       (stall_o),
    .fc_flush_btype_flag_o (flush_b_o),
    .fc_flush_jtype_flag_o (flush_j_o),
    .fc_jump_en_o          (jen_o),
    .fc_jump_addr_o        (jaddr_o),
    .fc_muldiv_timeout_o   (to_o),
    .fc_stall_cnt_o        (scnt_o),
    .fc_flush_cnt_o        (fcnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_busy;
  int          m_busy_cycles;
  bit          m_to;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;
  int          seen_stall;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_busy        = 1'b0;
    m_busy_cycles = 0;
    m_to          = 1'b0;
    m_stalls      = '0;
    m_flushes     = '0;
  endtask

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; rd = '0;
    re1 = 1'b0; re2 = 1'b0; load = 1'b0;
    taken = 1'b0; jump = 1'b0; target = '0;
    start = 1'b0; done = 1'b0;
  endtask

  // One clock: check outputs at negedge, advance model at posedge
  task automatic cycle();
    bit hz, redir, st, fb, fj;
    logic [31:0] e_addr, e_sc, e_fc;
    @(negedge clk);
    hz = load && rd != 0
         && ((re1 && rs1 == rd) || (re2 && rs2 == rd));
    fb = !m_busy && taken;
    fj = !m_busy && jump;
    redir = fb || fj;
    if (m_busy) st = !done;
    else        st = !redir && (hz || start);
    e_addr = redir ? target : 32'h0;
    if (!rst_n) begin
      st = 0; fb = 0; fj = 0; redir = 0; e_addr = 0;
    end
`ifdef FC_PERF_CNT_EN
    e_sc = m_stalls;
    e_fc = m_flushes;
`else
    e_sc = 0;
    e_fc = 0;
`endif
    chk("stall",   32'(stall_o),   32'(st));
    chk("flush_b", 32'(flush_b_o), 32'(fb));
    chk("flush_j", 32'(flush_j_o), 32'(fj));
    chk("jump_en", 32'(jen_o),     32'(redir));
    chk("jump_addr", jaddr_o, e_addr);
    chk("timeout", 32'(to_o), 32'(m_to));
    chk("stall_cnt", scnt_o, e_sc);
    chk("flush_cnt", fcnt_o, e_fc);
    seen_stall += int'(stall_o);
    @(posedge clk);
    if (rst_n) begin
      m_stalls  += 32'(st);
      m_flushes += 32'(redir);
      if (m_busy) begin
        if (done) begin
          m_busy = 0;
        end else if (m_busy_cycles == T) begin
          m_busy = 0;
          m_to   = 1;
        end
      end else if (start && !redir) begin
        m_busy = 1;
        m_busy_cycles = 0;
      end
    end
    #1;
    // count the BUSY cycle now beginning (1-based)
    if (m_busy) m_busy_cycles++;
  endtask

  task automatic load_use(input logic [4:0] r);
    idle_inputs();
    load = 1; rd = r; rs2 = r; re2 = 1;
    cycle();
    idle_inputs();
    cycle();
  endtask

  initial begin
    model_clear();
    seen_stall = 0;
    idle_inputs();
    // outputs must read 0 under reset even with active inputs
    taken = 1; jump = 1; target = 32'h1234; start = 1;
    load = 1; rd = 5'd3; rs1 = 5'd3; re1 = 1;
    cycle();
    cycle();
    idle_inputs();
    rst_n = 1;
    cycle();

    // load-use on rs2, then x0 and disabled-read variants
    load = 1; rd = 5; rs2 = 5; re2 = 1;
    cycle();
    idle_inputs();
    cycle();
    load = 1; rd = 0; rs2 = 0; re2 = 1;
    cycle();
    load = 1; rd = 5; rs2 = 5; re2 = 0;
    cycle();
    load = 1; rd = 7; rs1 = 7; re1 = 1;
    cycle();

    // branch wins over a simultaneous load-use
    idle_inputs();
    taken = 1; target = 32'h80;
    load = 1; rd = 5; rs2 = 5; re2 = 1;
    cycle();
    idle_inputs();
    jump = 1; taken = 1; target = 32'hdead_beef;
    cycle();
    idle_inputs();
    jump = 1; start = 1; target = 32'h40;
    cycle();
    idle_inputs();
    cycle();

    // mul/div with done ten cycles after start
    seen_stall = 0;
    start = 1;
    cycle();
    start = 0;
    for (int i = 1; i <= 9; i++) begin
      taken = (i == 4);
      target = 32'h100;
      cycle();
    end
    taken = 0; done = 1;
    cycle();
    done = 0;
    chk("md_len", 32'(seen_stall), 32'd10);
    cycle();

    // watchdog expiry, then a normal run keeps the sticky flag
    seen_stall = 0;
    start = 1;
    cycle();
    start = 0;
    for (int i = 0; i < 70; i++) cycle();
    chk("wd_len", 32'(seen_stall), 32'(T + 1));
    chk("wd_flag", 32'(to_o), 32'd1);
    start = 1;
    cycle();
    start = 0;
    repeat (3) cycle();
    done = 1;
    cycle();
    done = 0;
    cycle();
    chk("wd_sticky", 32'(to_o), 32'd1);

    // asynchronous reset on the 3rd BUSY cycle
    start = 1;
    cycle();
    start = 0;
    cycle();
    cycle();
    rst_n = 0;
    #1;
    chk("rst_async_stall", 32'(stall_o), 32'd0);
    chk("rst_async_to", 32'(to_o), 32'd0);
    model_clear();
    cycle();
    rst_n = 1;
    done = 1;
    cycle();
    done = 0;
    load_use(5'd9);

    // perf counters from a clean reset
    rst_n = 0;
    #1;
    model_clear();
    cycle();
    rst_n = 1;
    load_use(5'd1);
    load_use(5'd2);
    load_use(5'd3);
    jump = 1; target = 32'h200;
    cycle();
    idle_inputs();
    cycle();
    jump = 1; target = 32'h300;
    cycle();
    idle_inputs();
    cycle();
`ifdef FC_PERF_CNT_EN
    chk("perf_stall", scnt_o, 32'd3);
    chk("perf_flush", fcnt_o, 32'd2);
`else
    chk("perf_stall", scnt_o, 32'd0);
    chk("perf_flush", fcnt_o, 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      rd     = 5'($urandom_range(0, 3));
      re1    = 1'($urandom_range(0, 1));
      re2    = 1'($urandom_range(0, 1));
      load   = 1'($urandom_range(0, 1));
      taken  = ($urandom_range(0, 9) == 0);
      jump   = ($urandom_range(0, 9) == 0);
      target = $urandom;
      start  = ($urandom_range(0, 7) == 0);
      done   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        #1;
        model_clear();
        cycle();
        rst_n = 1;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/flow_ctrl.md
Name: flow_ctrl

Overview:
- Pipeline flow controller: produces the stall and flush flags consumed by the IF/ID and ID/EX pipeline registers and by PC generation.
- Detects load-use hazards (ID vs EX) and control redirects (taken branch or jump resolved in EX).
- Holds the front end for the full duration of a multi-cycle mul/div, tracked by a small FSM with a timeout watchdog.

Parameters:
- MULDIV_TIMEOUT, 64: maximum BUSY cycles before forced return to IDLE; must be at least 2.
- CNT_W, 7: watchdog counter width; must satisfy 2^CNT_W > MULDIV_TIMEOUT.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- id_rs1_addr_i  input  5  ID source register 1
- id_rs1_re_i  input  1  ID reads rs1
- id_rs2_addr_i  input  5  ID source register 2
- id_rs2_re_i  input  1  ID reads rs2
- ex_rd_addr_i  input  5  EX destination register
- ex_load_flag_i  input  1  EX instruction is a load writing rd
- ex_branch_taken_i  input  1  EX B-type resolved taken
- ex_jump_flag_i  input  1  EX JAL/JALR
- ex_target_addr_i  input  32  redirect target from EX
- ex_muldiv_start_i  input  1  EX issues a multi-cycle mul/div (1-cycle pulse)
- muldiv_done_i  input  1  mul/div result valid this cycle
- fc_stall_flag_o  output  1  hold IF/ID and PC
- fc_flush_btype_flag_o  output  1  flush due to taken branch
- fc_flush_jtype_flag_o  output  1  flush due to jump
- fc_jump_en_o  output  1  PC redirect enable
- fc_jump_addr_o  output  32  PC redirect target
- fc_muldiv_timeout_o  output  1  sticky watchdog error
- fc_stall_cnt_o  output  32  stall-cycle count (optional feature)
- fc_flush_cnt_o  output  32  flush-event count (optional feature)

Behaviour:
- Reset: FSM = IDLE, watchdog counter = 0, timeout flag = 0, perf counters = 0. All outputs read 0 during reset.
- Flag outputs are combinational from current inputs plus registered state, so each takes effect in the same cycle; the target pipeline registers sample them on the next clk edge.
- Load-use hazard: ex_load_flag_i=1 and ex_rd_addr_i != 0 and the EX rd matches an ID source whose read enable is set (rs1 with id_rs1_re_i, or rs2 with id_rs2_re_i).
  - Asserts stall for that cycle only.
  - x0 never causes a hazard.
- Redirect:
  - ex_branch_taken_i=1 → fc_flush_btype_flag_o=1.
  - ex_jump_flag_i=1 → fc_flush_jtype_flag_o=1.
  - Either one → fc_jump_en_o=1 and fc_jump_addr_o=ex_target_addr_i.
  - If neither, fc_jump_addr_o=0.
  - Both asserted together: both flush flags = 1.
- Priority: a flush asserted in the same cycle as a load-use hazard forces fc_stall_flag_o=0; the flush wins.
- FSM states:
  - IDLE → BUSY when ex_muldiv_start_i=1 and no flush this cycle; stall asserted in that start cycle.
  - BUSY: stall=1 and watchdog counter increments each cycle.
  - BUSY → IDLE when muldiv_done_i=1; stall=0 in the done cycle; counter cleared.
  - BUSY → IDLE when counter reaches MULDIV_TIMEOUT-1 without done; fc_muldiv_timeout_o set and stays set until reset; stall released in the following cycle.
- In BUSY, redirect inputs and load-use detection are masked, because EX is frozen.
- muldiv_done_i in IDLE is ignored.
- ex_muldiv_start_i in BUSY is ignored.
- Reset asserted mid-BUSY: immediate asynchronous return to IDLE; stall drops during reset.

Optional Feature:
- Macro FC_PERF_CNT_EN, defined:
  - fc_stall_cnt_o increments on every cycle with fc_stall_flag_o=1.
  - fc_flush_cnt_o increments on every cycle with either flush flag = 1.
  - Both counters are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Macro not defined: both ports remain present and are tied to 32'h0; no counter flops are synthesized.

Decomposition:
- Shared package `fc_pkg`:
  - FSM state encoding (FC_IDLE=1'b0, FC_BUSY=1'b1).
  - REG_X0 = 5'd0.
  - Width constants REG_ADDR_W=5 and XLEN=32.
- One natural sub-module, `fc_hazard_detect`: the purely combinational load-use comparator (register addresses and enables in, hazard out).
- FSM, watchdog and optional counters stay in flow_ctrl.

Test Plan:
- Load-use: ex_load=1, ex_rd=5, id_rs2=5, rs2_re=1 → stall=1 for one cycle. Repeat with ex_rd=0 → stall=0. Repeat with rs2_re=0 → stall=0.
- Branch plus hazard in the same cycle: taken=1, target=0x80, and a load-use match → flush_btype=1, jump_en=1, addr=0x80, stall=0.
- Mul/div: start pulse, done 10 cycles later → stall high for exactly the start cycle plus 9 BUSY cycles, low in the done cycle; a branch_taken pulse mid-BUSY produces no flush.
- Watchdog: start, never done, MULDIV_TIMEOUT=64 → stall drops after 64 BUSY cycles; timeout=1 and stays 1 while a second start/done runs normally.
- Reset on the 3rd BUSY cycle → stall=0 immediately; after release, FSM is IDLE and a done pulse has no effect.
- With FC_PERF_CNT_EN: 3 load-use stalls plus 2 jumps → stall_cnt=3, flush_cnt=2. Without the macro → both counters read 0.
